// File: rtl/fifo_port_out_nch.sv
// Multi-channel first-word-fall-through output FIFO port between the agent cluster and the accelerator.
// Each channel has its own buffer, occupancy/almost-full/full/empty status and sticky overflow/underflow flags.
module fifo_port_out_nch #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 16,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = $clog2(DEPTH) + 1,
  parameter int AFULL_THR = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        fp_outfifo_write,
  input  logic [NUM_CH*DATA_W-1:0] fp_outfifo_data,
  input  logic [NUM_CH*TAG_W-1:0]  fp_outfifo_pkt_tag,
  output logic [NUM_CH-1:0]        fp_outfifo_full,
  output logic [NUM_CH-1:0]        fp_outfifo_afull,
  output logic [NUM_CH*CNT_W-1:0]  fp_outfifo_full_count,
  input  logic [NUM_CH-1:0]        acc_rd,
  output logic [NUM_CH*DATA_W-1:0] fpo_data,
  output logic [NUM_CH*TAG_W-1:0]  fpo_ptag,
  output logic [NUM_CH-1:0]        fpo_empty,
  input  logic [NUM_CH-1:0]        err_clr,
  output logic [NUM_CH-1:0]        ovf_err,
  output logic [NUM_CH-1:0]        udf_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_mem_r [NUM_CH][DEPTH];
  logic [TAG_W-1:0]  tag_mem_r  [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r   [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_r   [NUM_CH];
  logic [CNT_W-1:0]  count_r    [NUM_CH];
  logic [NUM_CH-1:0] ovf_r;
  logic [NUM_CH-1:0] udf_r;
  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] push_acc_s;
  logic [NUM_CH-1:0] pop_acc_s;

  // Status decode from the registered count, acceptance, and head-of-FIFO presentation
  always_comb begin
    full_s                = '0;
    empty_s               = '0;
    push_acc_s            = '0;
    pop_acc_s             = '0;
    fp_outfifo_afull      = '0;
    fp_outfifo_full_count = '0;
    fpo_data              = '0;
    fpo_ptag              = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full_s[c]           = (count_r[c] == CNT_W'(DEPTH));
      empty_s[c]          = (count_r[c] == {CNT_W{1'b0}});
      fp_outfifo_afull[c] = (count_r[c] >= CNT_W'(AFULL_THR));
      push_acc_s[c]       = fp_outfifo_write[c] & ~full_s[c];
      pop_acc_s[c]        = acc_rd[c] & ~empty_s[c];
      fp_outfifo_full_count[c*CNT_W +: CNT_W] = count_r[c];
      // Empty channels present zero rather than stale RAM contents
      if (empty_s[c]) begin
        fpo_data[c*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        fpo_ptag[c*TAG_W +: TAG_W]   = {TAG_W{1'b0}};
      end else begin
        fpo_data[c*DATA_W +: DATA_W] = data_mem_r[c][rd_ptr_r[c]];
        fpo_ptag[c*TAG_W +: TAG_W]   = tag_mem_r[c][rd_ptr_r[c]];
      end
    end
  end

  // Storage write; the RAM is deliberately left out of reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_acc_s[c]) begin
        data_mem_r[c][wr_ptr_r[c]] <= fp_outfifo_data[c*DATA_W +: DATA_W];
        tag_mem_r[c][wr_ptr_r[c]]  <= fp_outfifo_pkt_tag[c*TAG_W +: TAG_W];
      end
    end
  end

  // Pointers, occupancy and sticky error flags per channel
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_r[c] <= {PTR_W{1'b0}};
        rd_ptr_r[c] <= {PTR_W{1'b0}};
        count_r[c]  <= {CNT_W{1'b0}};
      end
      ovf_r <= {NUM_CH{1'b0}};
      udf_r <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_acc_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + PTR_W'(1);
        end
        if (pop_acc_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + PTR_W'(1);
        end
        count_r[c] <= count_r[c] + CNT_W'(push_acc_s[c]) - CNT_W'(pop_acc_s[c]);
        // A new error event in the same cycle as a clear keeps the flag set
        ovf_r[c] <= (ovf_r[c] & ~err_clr[c]) | (fp_outfifo_write[c] & full_s[c]);
        udf_r[c] <= (udf_r[c] & ~err_clr[c]) | (acc_rd[c] & empty_s[c]);
      end
    end
  end

  assign fp_outfifo_full = full_s;
  assign fpo_empty       = empty_s;
  assign ovf_err         = ovf_r;
  assign udf_err         = udf_r;

endmodule

// File: tb/tb_fifo_port_out_nch.sv
// Directed self-checking bench for fifo_port_out_nch at default parameters.
module tb_fifo_port_out_nch;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 16;
  localparam int CNT_W  = 5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        fp_outfifo_write;
  logic [NUM_CH*DATA_W-1:0] fp_outfifo_data;
  logic [NUM_CH*TAG_W-1:0]  fp_outfifo_pkt_tag;
  logic [NUM_CH-1:0]        fp_outfifo_full;
  logic [NUM_CH-1:0]        fp_outfifo_afull;
  logic [NUM_CH*CNT_W-1:0]  fp_outfifo_full_count;
  logic [NUM_CH-1:0]        acc_rd;
  logic [NUM_CH*DATA_W-1:0] fpo_data;
  logic [NUM_CH*TAG_W-1:0]  fpo_ptag;
  logic [NUM_CH-1:0]        fpo_empty;
  logic [NUM_CH-1:0]        err_clr;
  logic [NUM_CH-1:0]        ovf_err;
  logic [NUM_CH-1:0]        udf_err;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_port_out_nch dut (
    .clk                   (clk),
    .reset                 (reset),
    .fp_outfifo_write      (fp_outfifo_write),
    .fp_outfifo_data       (fp_outfifo_data),
    .fp_outfifo_pkt_tag    (fp_outfifo_pkt_tag),
    .fp_outfifo_full       (fp_outfifo_full),
    .fp_outfifo_afull      (fp_outfifo_afull),
    .fp_outfifo_full_count (fp_outfifo_full_count),
    .acc_rd                (acc_rd),
    .fpo_data              (fpo_data),
    .fpo_ptag              (fpo_ptag),
    .fpo_empty             (fpo_empty),
    .err_clr               (err_clr),
    .ovf_err               (ovf_err),
    .udf_err               (udf_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past a rising edge and settle before sampling or re-driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fp_outfifo_write = '0;
    acc_rd           = '0;
    err_clr          = '0;
  endtask

  task automatic drive_push(input int c, input logic [31:0] d, input logic [15:0] t);
    fp_outfifo_write[c] = 1'b1;
    fp_outfifo_data[c*DATA_W +: DATA_W] = d;
    fp_outfifo_pkt_tag[c*TAG_W +: TAG_W] = t;
  endtask

  function automatic logic [4:0] cnt(input int c);
    return fp_outfifo_full_count[c*CNT_W +: CNT_W];
  endfunction

  function automatic logic [31:0] hd(input int c);
    return fpo_data[c*DATA_W +: DATA_W];
  endfunction

  function automatic logic [15:0] ht(input int c);
    return fpo_ptag[c*TAG_W +: TAG_W];
  endfunction

  initial begin
    reset = 1'b1;
    fp_outfifo_data = '0;
    fp_outfifo_pkt_tag = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_empty", fpo_empty, 4'b1111);
    check_eq("rst_count", fp_outfifo_full_count, 20'h0);
    check_eq("rst_data", fpo_data, 128'h0);
    check_eq("rst_ptag", fpo_ptag, 64'h0);
    check_eq("rst_full", fp_outfifo_full, 4'b0000);
    check_eq("rst_afull", fp_outfifo_afull, 4'b0000);
    check_eq("rst_ovf", ovf_err, 4'b0000);
    check_eq("rst_udf", udf_err, 4'b0000);

    // Reset mid-operation discards ch2 contents
    for (int i = 0; i < 7; i++) begin
      drive_push(2, 32'hAAAA_0000 + 32'(i), 16'(i));
      tick();
    end
    idle();
    check_eq("ch2_cnt7", cnt(2), 5'd7);
    check_eq("ch2_head", hd(2), 32'hAAAA_0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_cnt", cnt(2), 5'd0);
    check_eq("mid_rst_empty", fpo_empty, 4'b1111);
    check_eq("mid_rst_data", hd(2), 32'h0);

    // Fill ch0 to full with afull boundary
    for (int i = 0; i < 16; i++) begin
      drive_push(0, 32'h1000_0000 + 32'(i), 16'(i));
      tick();
      if (i == 0) begin
        check_eq("fwft_head", hd(0), 32'h1000_0000);
        check_eq("fwft_empty", fpo_empty[0], 1'b0);
      end
      if (i == 10) check_eq("afull_11", fp_outfifo_afull[0], 1'b0);
      if (i == 11) check_eq("afull_12", fp_outfifo_afull[0], 1'b1);
      if (i == 14) check_eq("full_15", fp_outfifo_full[0], 1'b0);
    end
    check_eq("full_16", fp_outfifo_full[0], 1'b1);
    check_eq("cnt_16", cnt(0), 5'd16);
    drive_push(0, 32'hBAD0_BAD0, 16'hBAD0);
    tick();
    idle();
    check_eq("ovf_17", ovf_err[0], 1'b1);
    check_eq("cnt_17", cnt(0), 5'd16);
    for (int i = 0; i < 16; i++) begin
      check_eq("drain0_data", hd(0), 32'h1000_0000 + 32'(i));
      check_eq("drain0_tag", ht(0), 16'(i));
      acc_rd[0] = 1'b1;
      tick();
    end
    idle();
    check_eq("drain0_empty", fpo_empty[0], 1'b1);
    check_eq("drain0_zero", hd(0), 32'h0);
    check_eq("drain0_udf", udf_err[0], 1'b0);
    err_clr[0] = 1'b1;
    tick();
    idle();
    check_eq("clr_ovf0", ovf_err[0], 1'b0);

    // ch1 push+pop at full: push lost, ovf sets
    for (int i = 0; i < 16; i++) begin
      drive_push(1, 32'h2000_0000 + 32'(i), 16'(i));
      tick();
    end
    drive_push(1, 32'hDEAD_BEEF, 16'hDEAD);
    acc_rd[1] = 1'b1;
    tick();
    idle();
    check_eq("full_pp_cnt", cnt(1), 5'd15);
    check_eq("full_pp_ovf", ovf_err[1], 1'b1);
    for (int i = 1; i < 16; i++) begin
      check_eq("drain1_data", hd(1), 32'h2000_0000 + 32'(i));
      acc_rd[1] = 1'b1;
      tick();
    end
    idle();
    check_eq("drain1_empty", fpo_empty[1], 1'b1);
    err_clr[1] = 1'b1;
    tick();
    idle();
    // ch1 push+pop at empty: push accepted, udf sets
    drive_push(1, 32'hCAFE_0001, 16'h0055);
    acc_rd[1] = 1'b1;
    tick();
    idle();
    check_eq("empty_pp_cnt", cnt(1), 5'd1);
    check_eq("empty_pp_udf", udf_err[1], 1'b1);
    check_eq("empty_pp_data", hd(1), 32'hCAFE_0001);
    check_eq("empty_pp_tag", ht(1), 16'h0055);
    acc_rd[1] = 1'b1;
    err_clr[1] = 1'b1;
    tick();
    idle();
    check_eq("ch1_clean", {ovf_err[1], udf_err[1], fpo_empty[1]}, 3'b001);

    // ch3 steady-state streaming across pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive_push(3, 32'h3000_0000 + 32'(i), 16'(i));
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      check_eq("stream_data", hd(3), 32'h3000_0000 + 32'(k));
      drive_push(3, 32'h3000_0000 + 32'(k + 3), 16'(k + 3));
      acc_rd[3] = 1'b1;
      tick();
      idle();
      check_eq("stream_cnt", cnt(3), 5'd3);
    end
    check_eq("stream_err", {ovf_err[3], udf_err[3]}, 2'b00);
    for (int i = 40; i < 43; i++) begin
      check_eq("stream_tail", hd(3), 32'h3000_0000 + 32'(i));
      check_eq("stream_tag", ht(3), 16'(i));
      acc_rd[3] = 1'b1;
      tick();
    end
    idle();
    check_eq("stream_empty", fpo_empty[3], 1'b1);

    // Channel isolation
    for (int i = 0; i < 5; i++) begin
      drive_push(0, 32'h4000_0000 + 32'(i), 16'(i));
      acc_rd[2] = 1'b1;
      tick();
    end
    idle();
    check_eq("iso_udf", udf_err, 4'b0100);
    check_eq("iso_ovf", ovf_err, 4'b0000);
    check_eq("iso_cnt0", cnt(0), 5'd5);
    check_eq("iso_empty", fpo_empty, 4'b1110);
    check_eq("iso_head0", hd(0), 32'h4000_0000);
    err_clr[2] = 1'b1;
    tick();
    idle();
    check_eq("iso_clr", udf_err, 4'b0000);

    // Error clear versus simultaneous set on ch0
    for (int i = 5; i < 16; i++) begin
      drive_push(0, 32'h4000_0000 + 32'(i), 16'(i));
      tick();
    end
    check_eq("ec_full", fp_outfifo_full[0], 1'b1);
    drive_push(0, 32'h5555_5555, 16'h5555);
    tick();
    idle();
    check_eq("ec_set", ovf_err[0], 1'b1);
    err_clr[0] = 1'b1;
    tick();
    idle();
    check_eq("ec_clr_alone", ovf_err[0], 1'b0);
    err_clr[0] = 1'b1;
    drive_push(0, 32'h6666_6666, 16'h6666);
    tick();
    idle();
    check_eq("ec_set_wins", ovf_err[0], 1'b1);
    check_eq("ec_cnt", cnt(0), 5'd16);
    check_eq("ec_head", hd(0), 32'h4000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
